// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter and MAR/data sequencer for shared memory
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_in_en,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_out_en,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              cur_id;
  logic              cur_we;
  logic [DATA_W-1:0] cur_wdata;
  logic              last_grant;
  logic              grant0;
  logic              grant1;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      cur_wdata   <= '0;
      last_grant  <= 1'b1;
      busy        <= 1'b0;
      mem_addr_en <= 1'b0;
      mem_addr    <= '0;
      mem_in_en   <= 1'b0;
      mem_in      <= '0;
      mem_out_en  <= 1'b0;
      req0_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rvalid <= 1'b0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      mem_addr_en <= 1'b0;
      mem_addr    <= '0;
      mem_in_en   <= 1'b0;
      mem_in      <= '0;
      mem_out_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cur_id      <= grant1;
            cur_we      <= grant1 ? req1_we : req0_we;
            cur_wdata   <= grant1 ? req1_wdata : req0_wdata;
            last_grant  <= grant1;
            busy        <= 1'b1;
            mem_addr_en <= 1'b1;
            mem_addr    <= grant1 ? req1_addr : req0_addr;
            state       <= ADDR;
          end
        end
        ADDR: begin
          mem_in_en  <= cur_we;
          mem_in     <= cur_we ? cur_wdata : '0;
          mem_out_en <= !cur_we;
          state      <= DATA;
        end
        DATA: begin
          // MAR now holds the address, so mem_out is the read result.
          if (!cur_we) begin
            if (cur_id) begin
              req1_rdata  <= mem_out;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= mem_out;
              req0_rvalid <= 1'b1;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [15:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [15:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_addr_en, mem_in_en, mem_out_en, busy;
  logic [15:0] mem_addr, mem_in, mem_out;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem_arr [0:255];
  logic [15:0] mar = 16'h0000;

  always #5 clk = ~clk;

  // Single-port memory model: MAR loads on addr_en, writes land at MAR, read follows MAR.
  always @(posedge clk) begin
    if (mem_addr_en) mar <= mem_addr;
    if (mem_in_en) mem_arr[mar[7:0]] <= mem_in;
  end
  assign mem_out = mem_arr[mar[7:0]];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_addr_en(mem_addr_en), .mem_addr(mem_addr), .mem_in_en(mem_in_en), .mem_in(mem_in),
    .mem_out_en(mem_out_en), .mem_out(mem_out), .busy(busy)
  );

  task test_reset;
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b1; #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    vectors++; if ({mem_addr_en, mem_in_en, mem_out_en, busy, req0_rvalid, req1_rvalid} !== 6'b0) begin miscompares++; $display("FAIL rst_strobes: got %b want 000000", {mem_addr_en, mem_in_en, mem_out_en, busy, req0_rvalid, req1_rvalid}); end
    vectors++; if ({mem_addr, mem_in, req0_rdata, req1_rdata} !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", {mem_addr, mem_in, req0_rdata, req1_rdata}); end
    @(negedge clk); req0_valid = 1'b0; rst = 1'b0;
  endtask

  task test_read0;
    @(negedge clk); req0_valid = 1; req0_we = 0; req0_addr = 16'h0000; #1;
    vectors++; if ({req0_ready, req1_ready, busy} !== 3'b100) begin miscompares++; $display("FAIL rd0_accept: got %b want 100", {req0_ready, req1_ready, busy}); end
    @(negedge clk); req0_valid = 0; #1;
    vectors++; if ({mem_addr_en, mem_out_en, busy} !== 3'b101 || mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rd0_addr: got %b/%h want 101/0000", {mem_addr_en, mem_out_en, busy}, mem_addr); end
    @(negedge clk); #1;
    vectors++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b001) begin miscompares++; $display("FAIL rd0_data: got %b want 001", {mem_addr_en, mem_in_en, mem_out_en}); end
    @(negedge clk); #1;
    vectors++; if ({req0_rvalid, req1_rvalid, busy} !== 3'b100 || req0_rdata !== 16'h1500) begin miscompares++; $display("FAIL rd0_rvalid: got %b/%h want 100/1500", {req0_rvalid, req1_rvalid, busy}, req0_rdata); end
    @(negedge clk); #1;
    vectors++; if (req0_rvalid !== 1'b0 || req0_rdata !== 16'h1500) begin miscompares++; $display("FAIL rd0_hold: got %b/%h want 0/1500", req0_rvalid, req0_rdata); end
  endtask

  task test_write_read1;
    @(negedge clk); req1_valid = 1; req1_we = 1; req1_addr = 16'h0010; req1_wdata = 16'hBEEF; #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL wr1_accept: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk); req1_valid = 0; #1;
    vectors++; if (mem_addr_en !== 1'b1 || mem_addr !== 16'h0010) begin miscompares++; $display("FAIL wr1_addr: got %b/%h want 1/0010", mem_addr_en, mem_addr); end
    @(negedge clk); #1;
    vectors++; if ({mem_in_en, mem_out_en} !== 2'b10 || mem_in !== 16'hBEEF) begin miscompares++; $display("FAIL wr1_data: got %b/%h want 10/beef", {mem_in_en, mem_out_en}, mem_in); end
    @(negedge clk); req1_valid = 1; req1_we = 0; #1;
    vectors++; if ({req0_rvalid, req1_rvalid, req1_ready} !== 3'b001) begin miscompares++; $display("FAIL wr1_norvalid: got %b want 001", {req0_rvalid, req1_rvalid, req1_ready}); end
    @(negedge clk); req1_valid = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    vectors++; if (req1_rvalid !== 1'b1 || req1_rdata !== 16'hBEEF || req0_rdata !== 16'h1500) begin miscompares++; $display("FAIL rd1_beef: got %b/%h/%h want 1/beef/1500", req1_rvalid, req1_rdata, req0_rdata); end
  endtask

  task test_round_robin;
    logic exp0;
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0001;
    req1_valid = 1; req1_we = 0; req1_addr = 16'h0002; #1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      vectors++; if ({req0_ready, req1_ready} !== {exp0, !exp0}) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, {exp0, !exp0}); end
      if (i > 0) begin
        vectors++;
        if (exp0 ? (req1_rvalid !== 1'b1 || req0_rvalid !== 1'b0 || req1_rdata !== 16'h2222)
                 : (req0_rvalid !== 1'b1 || req1_rvalid !== 1'b0 || req0_rdata !== 16'h1111)) begin
          miscompares++; $display("FAIL rr_rdata%0d: got %b%b/%h/%h", i, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata);
        end
      end
      @(negedge clk); if (i == 3) begin req0_valid = 0; req1_valid = 0; end #1;
      vectors++; if ({req0_ready, req1_ready, busy} !== 3'b001) begin miscompares++; $display("FAIL rr_busy%0d: got %b want 001", i, {req0_ready, req1_ready, busy}); end
      @(negedge clk); #1;
      @(negedge clk); #1;
    end
    vectors++; if ({req0_rvalid, req1_rvalid} !== 2'b01 || req1_rdata !== 16'h2222 || req0_rdata !== 16'h1111) begin miscompares++; $display("FAIL rr_last: got %b/%h/%h want 01/1111/2222", {req0_rvalid, req1_rvalid}, req0_rdata, req1_rdata); end
  endtask

  task test_back_to_back;
    @(negedge clk); req1_valid = 1; req1_we = 0; req1_addr = 16'h0002; #1;
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept1: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 0; req0_valid = 1; req0_we = 0; req0_addr = 16'h0000; #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wait_a: got %b want 0", req0_ready); end
    @(negedge clk); #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wait_b: got %b want 0", req0_ready); end
    @(negedge clk); #1;
    vectors++; if ({req1_rvalid, req0_ready} !== 2'b11) begin miscompares++; $display("FAIL b2b_overlap: got %b want 11", {req1_rvalid, req0_ready}); end
    @(negedge clk); req0_valid = 0; #1;
    vectors++; if (mem_addr_en !== 1'b1 || mem_addr !== 16'h0000) begin miscompares++; $display("FAIL b2b_addr: got %b/%h want 1/0000", mem_addr_en, mem_addr); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    vectors++; if ({req0_rvalid, req1_rvalid} !== 2'b10 || req0_rdata !== 16'h1500) begin miscompares++; $display("FAIL b2b_rd0: got %b/%h want 10/1500", {req0_rvalid, req1_rvalid}, req0_rdata); end
  endtask

  task test_reset_mid;
    @(negedge clk); req1_valid = 1; req1_we = 1; req1_addr = 16'h0020; req1_wdata = 16'hCAFE; #1;
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL rm_accept: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 0; req1_we = 0; #1;
    @(negedge clk); #1;
    vectors++; if (mem_in_en !== 1'b1 || mem_in !== 16'hCAFE) begin miscompares++; $display("FAIL rm_data: got %b/%h want 1/cafe", mem_in_en, mem_in); end
    #1 rst = 1'b1; #1;
    vectors++; if ({mem_addr_en, mem_in_en, mem_out_en, busy} !== 4'b0 || mem_in !== 16'h0) begin miscompares++; $display("FAIL rm_clear: got %b/%h want 0000/0000", {mem_addr_en, mem_in_en, mem_out_en, busy}, mem_in); end
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if ({req0_rvalid, req1_rvalid} !== 2'b00 || mem_arr[8'h20] !== 16'h0000) begin miscompares++; $display("FAIL rm_nowrite: got %b/%h want 00/0000", {req0_rvalid, req1_rvalid}, mem_arr[8'h20]); end
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0001;
    req1_valid = 1; req1_we = 0; req1_addr = 16'h0002; #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rm_tie: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    vectors++; if (req0_rvalid !== 1'b1 || req0_rdata !== 16'h1111) begin miscompares++; $display("FAIL rm_rd0: got %b/%h want 1/1111", req0_rvalid, req0_rdata); end
  endtask

  task test_drop_valid;
    @(negedge clk); req1_valid = 1; req1_we = 0; req1_addr = 16'h0002; #1;
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL dv_accept: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 0; req0_valid = 1; req0_we = 1; req0_addr = 16'h0030; req0_wdata = 16'h1234; #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL dv_ready: got %b want 0", req0_ready); end
    @(negedge clk); req0_valid = 0; #1;
    vectors++; if ({mem_in_en, mem_out_en} !== 2'b01) begin miscompares++; $display("FAIL dv_data: got %b want 01", {mem_in_en, mem_out_en}); end
    @(negedge clk); #1;
    vectors++; if ({req1_rvalid, req0_ready} !== 2'b10 || req1_rdata !== 16'h2222) begin miscompares++; $display("FAIL dv_rd1: got %b/%h want 10/2222", {req1_rvalid, req0_ready}, req1_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++; if ({mem_addr_en, mem_in_en, mem_out_en, busy} !== 4'b0) begin miscompares++; $display("FAIL dv_quiet%0d: got %b want 0000", i, {mem_addr_en, mem_in_en, mem_out_en, busy}); end
    end
    vectors++; if (mem_arr[8'h30] !== 16'h0000) begin miscompares++; $display("FAIL dv_mem: got %h want 0000", mem_arr[8'h30]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    mem_arr[0] = 16'h1500;
    mem_arr[1] = 16'h1111;
    mem_arr[2] = 16'h2222;
    test_reset();
    test_read0();
    test_write_read1();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_drop_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
